// File: rtl/fpr_wb_arbiter.sv
// Write-back arbiter for the FP register file: round-robin grant of one result
// source per cycle, registered write port, and per-register busy scoreboard.
module fpr_wb_arbiter #(
    parameter  int N_REQ   = 3,
    parameter  int MAX_FPR = 32,
    parameter  int FLEN    = 32,
    localparam int AW      = $clog2(MAX_FPR),
    localparam int PW      = $clog2(N_REQ)
) (
    input  logic                        clk_in,
    input  logic                        reset_in,
    input  logic [N_REQ-1:0]            req_vld,
    input  logic [N_REQ-1:0][AW-1:0]    req_addr,
    input  logic [N_REQ-1:0][FLEN-1:0]  req_data,
    output logic [N_REQ-1:0]            req_rdy,
    input  logic                        wr_hold,
    output logic                        Fd_wr,
    output logic [AW-1:0]               Fd_addr,
    output logic [FLEN-1:0]             Fd_data,
    input  logic                        sb_set,
    input  logic [AW-1:0]               sb_set_addr,
    output logic [MAX_FPR-1:0]          sb_busy
);

    logic [PW-1:0]      r_rr_ptr;
    logic               r_fd_wr;
    logic [AW-1:0]      r_fd_addr;
    logic [FLEN-1:0]    r_fd_data;
    logic [MAX_FPR-1:0] r_busy;

    logic               w_found;
    logic [PW-1:0]      w_gidx;
    logic [PW-1:0]      w_cand;
    logic [PW-1:0]      w_ptr_nxt;
    logic [N_REQ-1:0]   w_rdy;
    logic               w_xfer;
    int                 w_idx;

    // Round-robin search upward from r_rr_ptr; grant is suppressed in reset and on hold
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        w_idx   = 0;
        w_rdy   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx  = (int'(r_rr_ptr) + i) % N_REQ;
            w_cand = PW'(w_idx);
            if (!w_found && req_vld[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end else begin
                w_found = w_found;
            end
        end
        if (w_found && !wr_hold && reset_in) begin
            w_rdy[w_gidx] = 1'b1;
        end else begin
            w_rdy = '0;
        end
    end

    assign w_xfer  = |w_rdy;
    assign req_rdy = w_rdy;

    // Pointer advances to the requester just past the winner, with wrap
    always_comb begin
        if (w_gidx == PW'(N_REQ - 1)) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = w_gidx + PW'(1);
        end
    end

    // Arbitration pointer and registered write-port stage
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_rr_ptr  <= '0;
            r_fd_wr   <= 1'b0;
            r_fd_addr <= '0;
            r_fd_data <= '0;
        end else if (w_xfer) begin
            r_rr_ptr  <= w_ptr_nxt;
            r_fd_wr   <= 1'b1;
            r_fd_addr <= req_addr[w_gidx];
            r_fd_data <= req_data[w_gidx];
        end else begin
            r_fd_wr   <= 1'b0;
        end
    end

    // Busy scoreboard: a same-edge set belongs to a newer op, so it beats the clear
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_busy <= '0;
        end else begin
            for (int k = 0; k < MAX_FPR; k++) begin
                if (sb_set && (sb_set_addr == AW'(k))) begin
                    r_busy[k] <= 1'b1;
                end else if (r_fd_wr && (r_fd_addr == AW'(k))) begin
                    r_busy[k] <= 1'b0;
                end else begin
                    r_busy[k] <= r_busy[k];
                end
            end
        end
    end

    assign Fd_wr   = r_fd_wr;
    assign Fd_addr = r_fd_addr;
    assign Fd_data = r_fd_data;
    assign sb_busy = r_busy;

endmodule

// File: tb/tb_fpr_wb_arbiter.sv
// Directed bench for fpr_wb_arbiter: grant order, write-port timing, hold,
// scoreboard set/clear and asynchronous reset behaviour.
module tb_fpr_wb_arbiter;

    logic              clk_in = 1'b0;
    logic              reset_in;
    logic [2:0]        req_vld;
    logic [2:0][4:0]   req_addr;
    logic [2:0][31:0]  req_data;
    logic [2:0]        req_rdy;
    logic              wr_hold;
    logic              Fd_wr;
    logic [4:0]        Fd_addr;
    logic [31:0]       Fd_data;
    logic              sb_set;
    logic [4:0]        sb_set_addr;
    logic [31:0]       sb_busy;

    int checks = 0;
    int errors = 0;

    fpr_wb_arbiter #(.N_REQ(3), .MAX_FPR(32), .FLEN(32)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .req_vld(req_vld), .req_addr(req_addr), .req_data(req_data), .req_rdy(req_rdy),
        .wr_hold(wr_hold),
        .Fd_wr(Fd_wr), .Fd_addr(Fd_addr), .Fd_data(Fd_data),
        .sb_set(sb_set), .sb_set_addr(sb_set_addr), .sb_busy(sb_busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        reset_in = 1'b0; req_vld = 3'b111; wr_hold = 1'b0; sb_set = 1'b0; sb_set_addr = 5'd0;
        req_addr = '0; req_data = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (req_rdy !== 3'b000) begin errors++; $display("FAIL rst_rdy got %b exp 000", req_rdy); end
            checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL rst_busy got %h exp 0", sb_busy); end
            checks++; if (Fd_wr !== 1'b0) begin errors++; $display("FAIL rst_fdwr got %b exp 0", Fd_wr); end
            tick();
        end
        reset_in = 1'b1;
        #1;
        checks++; if (req_rdy !== 3'b001) begin errors++; $display("FAIL rst_first_grant got %b exp 001", req_rdy); end
        req_vld = 3'b000;
    endtask

    task automatic test_round_robin();
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [2:0]  exp_rdy;
        req_vld = 3'b111;
        req_addr[0] = 5'd1; req_addr[1] = 5'd2; req_addr[2] = 5'd3;
        req_data[0] = 32'hA; req_data[1] = 32'hB; req_data[2] = 32'hC;
        for (int i = 0; i < 6; i++) begin
            exp_rdy  = 3'b001 << (i % 3);
            exp_addr = 5'(i % 3 + 1);
            exp_data = 32'hA + 32'(i % 3);
            #1;
            checks++; if (req_rdy !== exp_rdy) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, req_rdy, exp_rdy); end
            tick();
            checks++; if (Fd_wr !== 1'b1 || Fd_addr !== exp_addr || Fd_data !== exp_data) begin
                errors++; $display("FAIL rr_write[%0d] got wr=%b a=%0d d=%h exp wr=1 a=%0d d=%h", i, Fd_wr, Fd_addr, Fd_data, exp_addr, exp_data);
            end
        end
        req_vld = 3'b000;
        tick();
        checks++; if (Fd_wr !== 1'b0 || Fd_addr !== 5'd3 || Fd_data !== 32'hC) begin
            errors++; $display("FAIL rr_idle got wr=%b a=%0d d=%h exp wr=0 a=3 d=c", Fd_wr, Fd_addr, Fd_data);
        end
    endtask

    task automatic test_lone_request();
        req_vld = 3'b100; req_addr[2] = 5'd7; req_data[2] = 32'h3F80_0000;
        #1;
        checks++; if (req_rdy !== 3'b100) begin errors++; $display("FAIL lone2_grant got %b exp 100", req_rdy); end
        tick();
        req_vld = 3'b000;
        checks++; if (Fd_wr !== 1'b1 || Fd_addr !== 5'd7 || Fd_data !== 32'h3F80_0000) begin
            errors++; $display("FAIL lone2_write got wr=%b a=%0d d=%h exp wr=1 a=7 d=3f800000", Fd_wr, Fd_addr, Fd_data);
        end
        req_vld = 3'b011;
        #1;
        checks++; if (req_rdy !== 3'b001) begin errors++; $display("FAIL ptr_wrap got %b exp 001", req_rdy); end
        req_vld = 3'b010; req_addr[1] = 5'd9; req_data[1] = 32'h1234;
        #1;
        checks++; if (req_rdy !== 3'b010) begin errors++; $display("FAIL lone1_grant got %b exp 010", req_rdy); end
        tick();
        req_vld = 3'b000;
        checks++; if (Fd_wr !== 1'b1 || Fd_addr !== 5'd9 || Fd_data !== 32'h1234) begin
            errors++; $display("FAIL lone1_write got wr=%b a=%0d d=%h exp wr=1 a=9 d=1234", Fd_wr, Fd_addr, Fd_data);
        end
    endtask

    task automatic test_hold();
        req_vld = 3'b001; req_addr[0] = 5'd4; req_data[0] = 32'h44;
        #1;
        checks++; if (req_rdy !== 3'b001) begin errors++; $display("FAIL hold_pre_grant got %b exp 001", req_rdy); end
        tick();
        wr_hold = 1'b1; req_vld = 3'b011; req_addr[1] = 5'd10; req_data[1] = 32'hAA;
        #1;
        checks++; if (Fd_wr !== 1'b1 || Fd_addr !== 5'd4) begin errors++; $display("FAIL hold_pending got wr=%b a=%0d exp wr=1 a=4", Fd_wr, Fd_addr); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (req_rdy !== 3'b000) begin errors++; $display("FAIL hold_rdy[%0d] got %b exp 000", c, req_rdy); end
            tick();
            checks++; if (Fd_wr !== 1'b0 || Fd_addr !== 5'd4) begin errors++; $display("FAIL hold_idle[%0d] got wr=%b a=%0d exp wr=0 a=4", c, Fd_wr, Fd_addr); end
        end
        wr_hold = 1'b0;
        #1;
        checks++; if (req_rdy !== 3'b010) begin errors++; $display("FAIL hold_release got %b exp 010", req_rdy); end
        tick();
        req_vld = 3'b000;
        checks++; if (Fd_wr !== 1'b1 || Fd_addr !== 5'd10 || Fd_data !== 32'hAA) begin
            errors++; $display("FAIL hold_after got wr=%b a=%0d d=%h exp wr=1 a=10 d=aa", Fd_wr, Fd_addr, Fd_data);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        sb_set = 1'b1; sb_set_addr = 5'd5;
        tick();
        sb_set = 1'b0;
        checks++; if (sb_busy !== 32'h20) begin errors++; $display("FAIL sb_set got %h exp 00000020", sb_busy); end
        tick();
        tick();
        req_vld = 3'b001; req_addr[0] = 5'd5; req_data[0] = 32'h55;
        tick();
        req_vld = 3'b000;
        checks++; if (Fd_wr !== 1'b1 || Fd_addr !== 5'd5 || sb_busy !== 32'h20) begin
            errors++; $display("FAIL sb_commit got wr=%b a=%0d busy=%h exp wr=1 a=5 busy=00000020", Fd_wr, Fd_addr, sb_busy);
        end
        tick();
        checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL sb_clear got %h exp 0", sb_busy); end
        sb_set = 1'b1; sb_set_addr = 5'd5;
        tick();
        sb_set = 1'b0;
        req_vld = 3'b001;
        tick();
        req_vld = 3'b000;
        sb_set = 1'b1; sb_set_addr = 5'd5;
        checks++; if (Fd_wr !== 1'b1 || Fd_addr !== 5'd5) begin errors++; $display("FAIL sb_commit2 got wr=%b a=%0d exp wr=1 a=5", Fd_wr, Fd_addr); end
        tick();
        sb_set = 1'b0;
        checks++; if (sb_busy !== 32'h20) begin errors++; $display("FAIL sb_set_wins got %h exp 00000020", sb_busy); end
        tick();
        checks++; if (sb_busy !== 32'h20) begin errors++; $display("FAIL sb_hold got %h exp 00000020", sb_busy); end
    endtask

    task automatic test_async_reset();
        sb_set = 1'b1; sb_set_addr = 5'd4;
        tick();
        sb_set_addr = 5'd6;
        tick();
        sb_set_addr = 5'd7;
        req_vld = 3'b010; req_addr[1] = 5'd1; req_data[1] = 32'h11;
        #1;
        checks++; if (req_rdy !== 3'b010) begin errors++; $display("FAIL ar_pre_grant got %b exp 010", req_rdy); end
        tick();
        sb_set = 1'b0;
        checks++; if (Fd_wr !== 1'b1 || sb_busy !== 32'hF0) begin errors++; $display("FAIL ar_pre got wr=%b busy=%h exp wr=1 busy=000000f0", Fd_wr, sb_busy); end
        #2;
        reset_in = 1'b0;
        #1;
        checks++; if (Fd_wr !== 1'b0 || Fd_addr !== 5'd0 || Fd_data !== 32'h0) begin
            errors++; $display("FAIL ar_fd got wr=%b a=%0d d=%h exp 0 0 0", Fd_wr, Fd_addr, Fd_data);
        end
        checks++; if (sb_busy !== 32'h0 || req_rdy !== 3'b000) begin errors++; $display("FAIL ar_busy_rdy got busy=%h rdy=%b exp 0 000", sb_busy, req_rdy); end
        req_vld = 3'b111; req_addr[0] = 5'd2; req_data[0] = 32'h22;
        tick();
        checks++; if (Fd_wr !== 1'b0) begin errors++; $display("FAIL ar_held got wr=%b exp 0", Fd_wr); end
        reset_in = 1'b1;
        #1;
        checks++; if (req_rdy !== 3'b001) begin errors++; $display("FAIL ar_restart got %b exp 001", req_rdy); end
        tick();
        req_vld = 3'b000;
        checks++; if (Fd_wr !== 1'b1 || Fd_addr !== 5'd2 || Fd_data !== 32'h22) begin
            errors++; $display("FAIL ar_first_write got wr=%b a=%0d d=%h exp wr=1 a=2 d=22", Fd_wr, Fd_addr, Fd_data);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lone_request();
        test_hold();
        test_scoreboard();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
